// File: rtl/im_access_arbiter.sv
// rtl/im_access_arbiter.sv - instruction memory arbiter between fetch and debug/loader ports
// Fetch wins ties unless debug has lost DBG_MAX_WAIT consecutive cycles.
module im_access_arbiter #(
    parameter logic [15:0] IM_BASE      = 16'h3000,
    parameter int          DEPTH_LOG2   = 8,
    parameter int          DBG_MAX_WAIT = 4
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  fetch_req,
    input  logic [15:0]           fetch_addr,
    output logic                  fetch_gnt,
    output logic                  fetch_rvalid,
    output logic [31:0]           fetch_rdata,
    output logic                  fetch_err,
    input  logic                  dbg_req,
    input  logic                  dbg_we,
    input  logic [15:0]           dbg_addr,
    input  logic [31:0]           dbg_wdata,
    output logic                  dbg_gnt,
    output logic                  dbg_rvalid,
    output logic [31:0]           dbg_rdata,
    output logic                  dbg_err,
    output logic [DEPTH_LOG2-1:0] mem_addr,
    output logic                  mem_we,
    output logic [31:0]           mem_wdata,
    input  logic [31:0]           mem_rdata
);

    localparam int              WW       = (DBG_MAX_WAIT < 1) ? 1 : $clog2(DBG_MAX_WAIT + 1);
    localparam logic [WW-1:0]   WAIT_MAX = WW'(DBG_MAX_WAIT);
    localparam logic [1:0]      OWN_NONE  = 2'd0;
    localparam logic [1:0]      OWN_FETCH = 2'd1;
    localparam logic [1:0]      OWN_DBG   = 2'd2;

    logic [WW-1:0]         wait_cnt;
    logic [1:0]            owner;
    logic                  rsp_err;
    logic                  rsp_rd;
    logic [31:0]           fetch_rdata_q;
    logic [31:0]           dbg_rdata_q;
    logic [DEPTH_LOG2-1:0] addr_q;
    logic [31:0]           wdata_q;

    logic                  dbg_win;
    logic [15:0]           acc_addr;
    logic [15:0]           acc_off;
    logic                  acc_ok;
    logic                  acc_hit;

    always_comb begin
        dbg_win   = rstn && dbg_req && (!fetch_req || wait_cnt == WAIT_MAX);
        dbg_gnt   = dbg_win;
        fetch_gnt = rstn && fetch_req && !dbg_win;
        acc_addr  = dbg_win ? dbg_addr : fetch_addr;
        acc_off   = acc_addr - IM_BASE;
        // addr[1:0] == off[1:0] + IM_BASE[1:0] (mod 4), so alignment can be judged from the offset
        acc_ok    = (acc_addr >= IM_BASE)
                 && ((acc_off[1:0] + IM_BASE[1:0]) == 2'b00)
                 && (32'(acc_off[15:2]) < (32'd1 << DEPTH_LOG2));
        acc_hit   = (fetch_gnt || dbg_gnt) && acc_ok;
        mem_we    = dbg_gnt && dbg_we && acc_ok;
        mem_addr  = acc_hit ? acc_off[DEPTH_LOG2+1:2] : addr_q;
        mem_wdata = mem_we ? dbg_wdata : wdata_q;
    end

    always_comb begin
        fetch_rvalid = (owner == OWN_FETCH);
        fetch_err    = fetch_rvalid && rsp_err;
        fetch_rdata  = fetch_rvalid ? (rsp_err ? 32'd0 : mem_rdata) : fetch_rdata_q;
        dbg_rvalid   = (owner == OWN_DBG) && rsp_rd;
        dbg_err      = (owner == OWN_DBG) && rsp_err;
        dbg_rdata    = dbg_rvalid ? (rsp_err ? 32'd0 : mem_rdata) : dbg_rdata_q;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wait_cnt      <= '0;
            owner         <= OWN_NONE;
            rsp_err       <= 1'b0;
            rsp_rd        <= 1'b0;
            fetch_rdata_q <= 32'd0;
            dbg_rdata_q   <= 32'd0;
            addr_q        <= '0;
            wdata_q       <= 32'd0;
        end else begin
            if (dbg_req && !dbg_gnt)
                wait_cnt <= (wait_cnt == WAIT_MAX) ? wait_cnt : wait_cnt + 1'b1;
            else
                wait_cnt <= '0;

            // Successful debug writes produce no response at all
            if (fetch_gnt) begin
                owner   <= OWN_FETCH;
                rsp_err <= !acc_ok;
                rsp_rd  <= 1'b1;
            end else if (dbg_gnt && (!dbg_we || !acc_ok)) begin
                owner   <= OWN_DBG;
                rsp_err <= !acc_ok;
                rsp_rd  <= !dbg_we;
            end else begin
                owner   <= OWN_NONE;
                rsp_err <= 1'b0;
                rsp_rd  <= 1'b0;
            end

            if (fetch_rvalid) fetch_rdata_q <= fetch_rdata;
            if (dbg_rvalid)   dbg_rdata_q   <= dbg_rdata;
            if (acc_hit)      addr_q        <= mem_addr;
            if (mem_we)       wdata_q       <= dbg_wdata;
        end
    end

endmodule

// File: doc/im_access_arbiter.md
Name: im_access_arbiter

Overview:
Shares the single-port synchronous instruction memory between the CPU fetch stage and the debug/program-loader port. Translates byte addresses in the user program region (base 0x3000) to word indices and enforces a starvation limit on the debug requester. Routes the one-cycle-latency read data back to whichever requester issued the access. Sits between the fetch stage and the instruction memory inside the instruction memory unit.

Parameters:
IM_BASE, 16'h3000, byte address of memory word 0
DEPTH_LOG2, 8, log2 of memory depth in 32-bit words
DBG_MAX_WAIT, 4, consecutive losing cycles before debug is forced to win (0 = debug always wins)

Ports:
clk  input  1  system clock, rising edge
rstn  input  1  asynchronous active-low reset
fetch_req  input  1  fetch read request
fetch_addr  input  16  fetch byte address
fetch_gnt  output  1  fetch request accepted this cycle (combinational)
fetch_rvalid  output  1  fetch read response valid
fetch_rdata  output  32  fetch read data
fetch_err  output  1  fetch response is an error (qualifies fetch_rvalid)
dbg_req  input  1  debug request
dbg_we  input  1  debug request is a write
dbg_addr  input  16  debug byte address
dbg_wdata  input  32  debug write data
dbg_gnt  output  1  debug request accepted this cycle (combinational)
dbg_rvalid  output  1  debug read response valid (reads only)
dbg_rdata  output  32  debug read data
dbg_err  output  1  debug response/write error, 1-cycle pulse
mem_addr  output  DEPTH_LOG2  memory word index
mem_we  output  1  memory write enable
mem_wdata  output  32  memory write data
mem_rdata  input  32  memory read data, valid the cycle after the address

Behaviour:
- Reset (rstn low, async): rvalids, errs, rdata regs = 0; wait counter = 0; response owner = NONE; gnt and mem_we forced 0 while rstn low.
- Arbitration (combinational, per cycle): at most one gnt. Only one req -> that one granted. Both req -> fetch wins unless wait counter == DBG_MAX_WAIT, then debug wins.
- Wait counter: +1 each cycle dbg_req=1 and dbg_gnt=0, saturating at DBG_MAX_WAIT; cleared on dbg_gnt or dbg_req=0.
- Address check: off = addr - IM_BASE (16-bit). Valid iff addr >= IM_BASE, addr[1:0]==0, off[15:2] < 2**DEPTH_LOG2. mem_addr = off[DEPTH_LOG2+1:2].
- Granted valid read: mem_addr driven same cycle, mem_we=0; next cycle owner's rvalid=1, rdata=mem_rdata, err=0.
- Granted invalid read: no memory access; next cycle rvalid=1, rdata=0, err=1.
- Granted debug write: valid -> mem_we=1, mem_wdata=dbg_wdata same cycle, no rvalid; invalid -> mem_we=0, dbg_err pulses next cycle, dbg_rvalid stays 0.
- mem_we=1 only in a cycle with a valid debug write granted; mem_addr/mem_wdata are don't-care otherwise but hold last value (no glitching to X).
- Latency: read response exactly 1 cycle after gnt; back-to-back grants give back-to-back responses, one per cycle, to the correct owner.
- rdata outputs hold last response value when rvalid=0.
- Reset mid-operation: pending response discarded, no rvalid after reset release for pre-reset grants.
- Requesters hold req/addr/data until gnt; the block does not register requests.

Test Plan:
- Fetch read 0x3004, mem[1]=0xDEADBEEF -> fetch_gnt same cycle, mem_addr=1; next cycle fetch_rvalid=1, fetch_rdata=0xDEADBEEF, fetch_err=0.
- Debug write 0x3008 data 0x12345678, then debug read 0x3008 -> mem_we=1 with mem_addr=2; read returns dbg_rdata=0x12345678, no dbg_rvalid for the write.
- Fetch 0x2FFC, 0x3002, 0x3400 (DEPTH_LOG2=8) -> each granted, mem_we=0, fetch_rvalid=1, fetch_err=1, fetch_rdata=0.
- fetch_req and dbg_req held high continuously, DBG_MAX_WAIT=4 -> fetch granted 4 cycles, debug granted 5th cycle, counter cleared, pattern repeats.
- Alternating fetch/debug reads to 0x3000/0x3004 on consecutive cycles -> responses arrive next cycle each, routed to correct requester, never both rvalid.
- Grant debug read, assert rstn low for 1 cycle before response -> no dbg_rvalid after release, counter 0, all outputs 0.
